// File: rtl/sa48_slice_sequencer_if.sv
// rtl/sa48_slice_sequencer_if.sv - operand/slice bundle between a producer and the slice sequencer
//
// Purpose: groups the operand handshake (opValid/opReady/opA/opB) and the
// slice-side bus (outBusA/outBusB/shiftNext/sliceReady/sliceIdx/lastSlice/done)
// into one bundle.
//   slave  : the sequencer's view (takes operands, drives slices)
//   master : the producer/consumer view (drives operands, sees slices)
interface sa48_slice_sequencer_if #(
    parameter int WORD_W  = 48,
    parameter int SLICE_W = 12
);
    localparam int NSLICE = WORD_W / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    logic               opValid;
    logic               opReady;
    logic [WORD_W-1:0]  opA;
    logic [WORD_W-1:0]  opB;
    logic [SLICE_W-1:0] outBusA;
    logic [SLICE_W-1:0] outBusB;
    logic               shiftNext;
    logic               sliceReady;
    logic [IDX_W-1:0]   sliceIdx;
    logic               lastSlice;
    logic               done;

    modport slave (
        input  opValid,
        input  opA,
        input  opB,
        input  sliceReady,
        output opReady,
        output outBusA,
        output outBusB,
        output shiftNext,
        output sliceIdx,
        output lastSlice,
        output done
    );

    modport master (
        output opValid,
        output opA,
        output opB,
        output sliceReady,
        input  opReady,
        input  outBusA,
        input  outBusB,
        input  shiftNext,
        input  sliceIdx,
        input  lastSlice,
        input  done
    );
endinterface

// File: rtl/sa48_slice_sequencer.sv
// rtl/sa48_slice_sequencer.sv - splits a 48-bit operand pair into LSB-first 12-bit slice pairs
//
// Purpose: accepts one operand pair through opValid/opReady, then presents it
// as NSLICE slice pairs on outBusA/outBusB with shiftNext as the slice-valid
// strobe; each slice advances when sliceReady is high. A one-cycle done pulse
// follows the last accepted slice.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   flush  : synchronous abort back to IDLE (wins over load and slice advance)
//   bus    : slave modport of sa48_slice_sequencer_if
//            (opValid/opReady/opA/opB in, outBusA/outBusB/shiftNext/sliceIdx/
//             lastSlice/done out, sliceReady in)
// All outputs are decoded from registered state only.
module sa48_slice_sequencer #(
    parameter int WORD_W  = 48,
    parameter int SLICE_W = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    sa48_slice_sequencer_if.slave      bus
);
    localparam int NSLICE = WORD_W / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] a_q, a_d;
    logic [WORD_W-1:0] b_q, b_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.opValid) begin
                    a_d     = bus.opA;
                    b_d     = bus.opB;
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bus.sliceReady) begin
                    // Zero fill means the registers are empty once the last
                    // slice has gone, so the buses read 0 outside SEND.
                    a_d = a_q >> SLICE_W;
                    b_d = b_q >> SLICE_W;
                    if (cnt_q == LAST_IDX) begin
                        // Counter parks on the last index rather than wrapping.
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything decided above on this edge.
        if (flush) begin
            state_d = ST_IDLE;
            a_d     = '0;
            b_d     = '0;
            cnt_d   = '0;
        end
    end

    logic in_send;
    assign in_send = (state_q == ST_SEND);

    assign bus.opReady   = (state_q == ST_IDLE);
    assign bus.shiftNext = in_send;
    assign bus.outBusA   = in_send ? a_q[SLICE_W-1:0] : '0;
    assign bus.outBusB   = in_send ? b_q[SLICE_W-1:0] : '0;
    assign bus.sliceIdx  = cnt_q;
    assign bus.lastSlice = in_send && (cnt_q == LAST_IDX);
    assign bus.done      = (state_q == ST_DONE);

endmodule

// File: doc/sa48_slice_sequencer.md
Name: sa48_slice_sequencer

Overview:
Front-end feeder for the 48-bit sequential adder datapath. It accepts a pair of full-width operands through a valid/ready handshake. It then issues them LSB-first as four 12-bit slice pairs on the buses that drive the 12-bit adder, strobing shiftNext once per slice so the datapath shifts each result into its 48-bit output register. Where the datapath assembles slices into words, this block splits words into slices.

Parameters:
WORD_W, 48, operand width; must be an integer multiple of SLICE_W.
SLICE_W, 12, slice width per adder pass.
NSLICE (localparam), WORD_W/SLICE_W = 4, slices per operation.
IDX_W (localparam), clog2(NSLICE) = 2, width of sliceIdx.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort; returns the block to IDLE
opValid  input  1  operand pair valid
opReady  output  1  block can accept an operand pair
opA  input  WORD_W  operand A
opB  input  WORD_W  operand B
outBusA  output  SLICE_W  current slice of A (to adder A input)
outBusB  output  SLICE_W  current slice of B (to adder B input)
shiftNext  output  1  slice valid; datapath shift strobe
sliceReady  input  1  downstream accepts the current slice
sliceIdx  output  IDX_W  index of the current slice, 0 = LSB
lastSlice  output  1  current slice is index NSLICE-1
done  output  1  one-cycle pulse after the last slice is accepted

Behaviour:
- Single clock domain. Reset is asynchronous and active-low: clk and rst_n, with rst_n asserted low clearing all state immediately.
- Reset values: state=IDLE, shift registers=0, slice counter=0. Outputs after reset: opReady=1, shiftNext=0, outBusA=outBusB=0, sliceIdx=0, lastSlice=0, done=0.
- FSM has three states: IDLE, SEND, DONE.
- IDLE:
  - opReady=1.
  - On opValid, latch opA/opB into the shift registers, clear the counter, and go to SEND.
- SEND:
  - opReady=0, shiftNext=1.
  - outBusA/outBusB = low SLICE_W bits of the shift registers.
  - lastSlice = (sliceIdx==NSLICE-1).
  - A transfer occurs on a cycle with shiftNext=1 and sliceReady=1. On a transfer, both registers shift right by SLICE_W with zero fill and the counter increments.
  - A transfer on the last slice moves to DONE.
  - With sliceReady=0, all outputs hold their values (no advance, no data change).
- DONE:
  - done=1 for exactly one cycle, opReady=0, shiftNext=0.
  - Next state is IDLE unconditionally.
- Latency, with the operand accepted at edge N and sliceReady held high:
  - slices valid in cycles N+1..N+4;
  - done in cycle N+5;
  - opReady high again in cycle N+6.
- Outputs are decoded from registered state only; there is no combinational path from any input to any output.
- outBusA/outBusB read 0 in IDLE and DONE, because the registers have shifted fully out or been cleared.
- opValid while opReady=0 is ignored; the operand is not captured and no error is flagged.
- flush=1 at any clock edge:
  - next state IDLE, registers and counter cleared;
  - done is not pulsed;
  - flush has priority over opValid and over a slice transfer on the same edge.
- Asynchronous reset mid-operation aborts immediately with no done pulse; the partial slices already sent are not retracted.
- The counter never wraps within an operation; it returns to 0 only via load, flush or reset.

Test Plan:
- Reset: assert rst_n=0 between clock edges during SEND -> outputs take reset values before the next edge: opReady=1, shiftNext=0, outBusA=0, done=0.
- Basic op: opA=48'h123456789ABC, opB=48'hFEDCBA987654, sliceReady=1 ->
  - outBusA = ABC, 789, 456, 123 and outBusB = 654, 987, CBA, FED in cycles N+1..N+4;
  - sliceIdx 0..3, lastSlice=1 only in cycle N+4;
  - done=1 in N+5, opReady=1 in N+6.
- Backpressure: sliceReady=0 for 3 cycles while sliceIdx=1 -> outBusA=789 and outBusB=987 held; sliceIdx stays 1; done delayed by 3 cycles.
- Ignored operand: opValid=1 with opA=48'hFFFFFFFFFFFF during SEND -> slices of the original operand are unaffected. The first op is completed first; the second op is accepted in the IDLE cycle and yields FFF on every slice.
- Flush: flush=1 at sliceIdx=2 -> next cycle shiftNext=0, opReady=1, outBusA=0; no done pulse. A simultaneous sliceReady=1 does not advance the slice.
- Back-to-back: two ops issued with opValid held high -> eight slices, with exactly two cycles (DONE plus the IDLE accept) between the last slice of op 1 and the first slice of op 2.
